// File: rtl/cu_pipe5_if.sv
// Control-unit bus: ID-stage instruction fields in, stage controls and hazard handshake out.
interface cu_pipe5_if #(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 6,
    parameter int RA_W   = 5,
    parameter int ALUC_W = 5
);
    logic              id_valid;
    logic [OP_W-1:0]   op;
    logic [FUNC_W-1:0] func;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic              zero;

    logic              PCWre;
    logic              IRWre;
    logic              id_flush;
    logic [ALUC_W-1:0] ALUControl;
    logic              ALUSrcA;
    logic              ALUSrcB;
    logic              Extend;
    logic [1:0]        Branch;
    logic              MemWrite;
    logic              MemtoReg;
    logic              PCtoReg;
    logic              RegWrite;
    logic [RA_W-1:0]   wb_rdst;
    logic              illegal;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    // Datapath / instruction-register side
    modport master (
        output id_valid, op, func, rs, rt, rd, zero,
        input  PCWre, IRWre, id_flush, ALUControl, ALUSrcA, ALUSrcB, Extend, Branch,
               MemWrite, MemtoReg, PCtoReg, RegWrite, wb_rdst, illegal, fwd_a, fwd_b
    );

    // Control-unit side
    modport slave (
        input  id_valid, op, func, rs, rt, rd, zero,
        output PCWre, IRWre, id_flush, ALUControl, ALUSrcA, ALUSrcB, Extend, Branch,
               MemWrite, MemtoReg, PCtoReg, RegWrite, wb_rdst, illegal, fwd_a, fwd_b
    );
endinterface

// File: rtl/cu_pipe5.sv
// Five-stage pipeline control unit: ID decode, EX/MEM/WB control stages, hazard stall and flush.
// Optional operand forwarding is enabled by defining CU_PIPE5_FORWARD_EN.
module cu_pipe5 #(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 6,
    parameter int RA_W   = 5,
    parameter int ALUC_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    cu_pipe5_if.slave bus
);
    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'h0d);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2b);

    localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(6'h20);
    localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(6'h22);
    localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(6'h24);
    localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(6'h25);
    localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(6'h2a);
    localparam logic [FUNC_W-1:0] F_SLL = FUNC_W'(6'h00);

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(5'b00000);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(5'b00001);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(5'b00010);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(5'b00011);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(5'b00100);
    localparam logic [ALUC_W-1:0] ALU_SLL = ALUC_W'(5'b00101);

    localparam logic [RA_W-1:0] RA_LINK = RA_W'(31);

    typedef struct packed {
        logic [ALUC_W-1:0] alu;
        logic              srca;
        logic              srcb;
        logic              ext;
        logic              beq;
        logic              bne;
        logic              jmp;
        logic              mw;
        logic              m2r;
        logic              pc2r;
        logic              rw;
        logic [RA_W-1:0]   dst;
    } ctl_t;

    // ---------------- ID decode ----------------
    ctl_t            dec;
    logic            dec_ok;
    logic [RA_W-1:0] src_a;   // registers actually read; 0 when the field is not a source
    logic [RA_W-1:0] src_b;

    always_comb begin
        dec    = '0;
        dec_ok = 1'b0;
        src_a  = '0;
        src_b  = '0;
        case (bus.op)
            OP_R: begin
                dec_ok  = 1'b1;
                dec.rw  = 1'b1;
                dec.dst = bus.rd;
                src_a   = bus.rs;
                src_b   = bus.rt;
                case (bus.func)
                    F_ADD: dec.alu = ALU_ADD;
                    F_SUB: dec.alu = ALU_SUB;
                    F_AND: dec.alu = ALU_AND;
                    F_OR:  dec.alu = ALU_OR;
                    F_SLT: dec.alu = ALU_SLT;
                    F_SLL: begin
                        dec.alu  = ALU_SLL;
                        dec.srca = 1'b1;
                        src_a    = '0;
                    end
                    default: begin
                        dec    = '0;
                        dec_ok = 1'b0;
                        src_a  = '0;
                        src_b  = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_ok   = 1'b1;
                dec.srcb = 1'b1;
                dec.ext  = 1'b1;
                dec.alu  = ALU_ADD;
                dec.rw   = 1'b1;
                dec.dst  = bus.rt;
                src_a    = bus.rs;
            end
            OP_ORI: begin
                dec_ok   = 1'b1;
                dec.srcb = 1'b1;
                dec.alu  = ALU_OR;
                dec.rw   = 1'b1;
                dec.dst  = bus.rt;
                src_a    = bus.rs;
            end
            OP_LW: begin
                dec_ok   = 1'b1;
                dec.srcb = 1'b1;
                dec.ext  = 1'b1;
                dec.alu  = ALU_ADD;
                dec.m2r  = 1'b1;
                dec.rw   = 1'b1;
                dec.dst  = bus.rt;
                src_a    = bus.rs;
            end
            OP_SW: begin
                dec_ok   = 1'b1;
                dec.srcb = 1'b1;
                dec.ext  = 1'b1;
                dec.alu  = ALU_ADD;
                dec.mw   = 1'b1;
                src_a    = bus.rs;
                src_b    = bus.rt;
            end
            OP_BEQ, OP_BNE: begin
                dec_ok  = 1'b1;
                dec.alu = ALU_SUB;
                dec.ext = 1'b1;
                dec.beq = (bus.op == OP_BEQ);
                dec.bne = (bus.op == OP_BNE);
                src_a   = bus.rs;
                src_b   = bus.rt;
            end
            OP_J: begin
                dec_ok  = 1'b1;
                dec.jmp = 1'b1;
            end
            OP_JAL: begin
                dec_ok   = 1'b1;
                dec.jmp  = 1'b1;
                dec.pc2r = 1'b1;
                dec.rw   = 1'b1;
                dec.dst  = RA_LINK;
            end
            default: ;
        endcase
        if (!bus.id_valid) begin
            dec    = '0;
            dec_ok = 1'b0;
            src_a  = '0;
            src_b  = '0;
        end
        if (dec.dst == '0) dec.rw = 1'b0;
    end

    // ---------------- stage registers ----------------
    logic [3:1]      vld_pipe;   // [1]=EX, [2]=MEM, [3]=WB
    ctl_t            ex_c;
    logic            mem_mw, mem_m2r, mem_pc2r, mem_rw;
    logic [RA_W-1:0] mem_dst;
    logic            wb_m2r, wb_pc2r, wb_rw;
    logic [RA_W-1:0] wb_dst;
    logic            ill_q;

    logic taken, jump, flush, hazard, stall, load, ex_hit;

    assign taken  = vld_pipe[1] & ((ex_c.beq & bus.zero) | (ex_c.bne & ~bus.zero));
    assign jump   = vld_pipe[1] & ex_c.jmp;
    assign flush  = taken | jump;
    // rw is already cleared for destination 0, and unused sources read as 0
    assign ex_hit = vld_pipe[1] & ex_c.rw & ((ex_c.dst == src_a) | (ex_c.dst == src_b));
    assign stall  = hazard & ~flush;
    assign load   = dec_ok & ~flush & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            ex_c     <= '0;
            mem_mw   <= 1'b0;
            mem_m2r  <= 1'b0;
            mem_pc2r <= 1'b0;
            mem_rw   <= 1'b0;
            mem_dst  <= '0;
            wb_m2r   <= 1'b0;
            wb_pc2r  <= 1'b0;
            wb_rw    <= 1'b0;
            wb_dst   <= '0;
            ill_q    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[2:1], load};
            ex_c     <= load ? dec : '0;
            mem_mw   <= ex_c.mw;
            mem_m2r  <= ex_c.m2r;
            mem_pc2r <= ex_c.pc2r;
            mem_rw   <= ex_c.rw;
            mem_dst  <= ex_c.dst;
            wb_m2r   <= mem_m2r;
            wb_pc2r  <= mem_pc2r;
            wb_rw    <= mem_rw;
            wb_dst   <= mem_dst;
            ill_q    <= bus.id_valid & ~dec_ok & ~flush & ~stall;
        end
    end

`ifdef CU_PIPE5_FORWARD_EN
    logic [RA_W-1:0] ex_ra, ex_rb;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ra <= '0;
            ex_rb <= '0;
        end else begin
            ex_ra <= load ? src_a : '0;
            ex_rb <= load ? src_b : '0;
        end
    end

    // MEM result is younger than WB, so it wins
    always_comb begin
        bus.fwd_a = 2'b00;
        bus.fwd_b = 2'b00;
        if (vld_pipe[1]) begin
            if (vld_pipe[2] && mem_rw && mem_dst == ex_ra)     bus.fwd_a = 2'b10;
            else if (vld_pipe[3] && wb_rw && wb_dst == ex_ra)  bus.fwd_a = 2'b01;
            if (vld_pipe[2] && mem_rw && mem_dst == ex_rb)     bus.fwd_b = 2'b10;
            else if (vld_pipe[3] && wb_rw && wb_dst == ex_rb)  bus.fwd_b = 2'b01;
        end
    end

    assign hazard = ex_hit & ex_c.m2r;
`else
    logic mem_hit;
    assign mem_hit   = vld_pipe[2] & mem_rw & ((mem_dst == src_a) | (mem_dst == src_b));
    assign hazard    = ex_hit | mem_hit;
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    // ---------------- outputs ----------------
    assign bus.PCWre      = ~stall;
    assign bus.IRWre      = ~stall;
    assign bus.id_flush   = flush;
    assign bus.ALUControl = vld_pipe[1] ? ex_c.alu : '0;
    assign bus.ALUSrcA    = vld_pipe[1] & ex_c.srca;
    assign bus.ALUSrcB    = vld_pipe[1] & ex_c.srcb;
    assign bus.Extend     = vld_pipe[1] & ex_c.ext;
    assign bus.Branch     = jump ? 2'b10 : (taken ? 2'b01 : 2'b00);
    assign bus.MemWrite   = vld_pipe[2] & mem_mw;
    assign bus.MemtoReg   = vld_pipe[3] & wb_m2r;
    assign bus.PCtoReg    = vld_pipe[3] & wb_pc2r;
    assign bus.RegWrite   = vld_pipe[3] & wb_rw;
    assign bus.wb_rdst    = vld_pipe[3] ? wb_dst : '0;
    assign bus.illegal    = ill_q;
endmodule

// File: tb/tb_cu_pipe5.sv
// Bench for cu_pipe5: instruction-level pipeline model checked every cycle, plus hand-computed directed expectations.
module tb_cu_pipe5;
    localparam int OP_W = 6, FUNC_W = 6, RA_W = 5, ALUC_W = 5;

`ifdef CU_PIPE5_FORWARD_EN
    localparam int N_LU  = 1;   // lw -> use stall cycles
    localparam int N_RAW = 0;   // alu -> use stall cycles
`else
    localparam int N_LU  = 2;
    localparam int N_RAW = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cu_pipe5_if #(.OP_W(OP_W), .FUNC_W(FUNC_W), .RA_W(RA_W), .ALUC_W(ALUC_W)) bus ();
    cu_pipe5 #(.OP_W(OP_W), .FUNC_W(FUNC_W), .RA_W(RA_W), .ALUC_W(ALUC_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] func;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    // What an instruction means, independent of any stage structure
    typedef struct packed {
        logic       ok;
        logic [4:0] alu;
        logic       srca, srcb, ext, beq, bne, jmp, mw, m2r, pc2r, rw;
        logic [4:0] dst, ra, rb;
    } mc_t;

    int checks = 0;
    int errors = 0;

    ins_t prog[$];
    ins_t id_cur;
    int   ptr;
    logic zval;
    mc_t  m_ex, m_mem, m_wb;
    logic m_ill;

    int tr_pcw[32], tr_irw[32], tr_fl[32], tr_br[32], tr_rw[32], tr_rd[32];
    int tr_pc2r[32], tr_alu[32], tr_srcb[32], tr_ill[32], tr_mw[32], tr_fa[32], tr_fb[32];

    function automatic ins_t mk(logic [5:0] op, logic [5:0] f, logic [4:0] s, logic [4:0] t, logic [4:0] d);
        ins_t i;
        i = '{v: 1'b1, op: op, func: f, rs: s, rt: t, rd: d};
        return i;
    endfunction

    function automatic mc_t mdec(ins_t i);
        mc_t c;
        c = '0;
        if (!i.v) return c;
        c.ok = 1'b1;
        case (i.op)
            6'h00: begin
                c.rw = 1'b1; c.dst = i.rd; c.ra = i.rs; c.rb = i.rt;
                case (i.func)
                    6'h20: c.alu = 5'd0;
                    6'h22: c.alu = 5'd1;
                    6'h24: c.alu = 5'd2;
                    6'h25: c.alu = 5'd3;
                    6'h2a: c.alu = 5'd4;
                    6'h00: begin c.alu = 5'd5; c.srca = 1'b1; c.ra = 5'd0; end
                    default: c = '0;
                endcase
            end
            6'h08: begin c.srcb = 1; c.ext = 1; c.rw = 1; c.dst = i.rt; c.ra = i.rs; end
            6'h0d: begin c.srcb = 1; c.alu = 5'd3; c.rw = 1; c.dst = i.rt; c.ra = i.rs; end
            6'h23: begin c.srcb = 1; c.ext = 1; c.m2r = 1; c.rw = 1; c.dst = i.rt; c.ra = i.rs; end
            6'h2b: begin c.srcb = 1; c.ext = 1; c.mw = 1; c.ra = i.rs; c.rb = i.rt; end
            6'h04: begin c.alu = 5'd1; c.ext = 1; c.beq = 1; c.ra = i.rs; c.rb = i.rt; end
            6'h05: begin c.alu = 5'd1; c.ext = 1; c.bne = 1; c.ra = i.rs; c.rb = i.rt; end
            6'h02: c.jmp = 1;
            6'h03: begin c.jmp = 1; c.pc2r = 1; c.rw = 1; c.dst = 5'd31; end
            default: c = '0;
        endcase
        if (c.dst == 5'd0) c.rw = 1'b0;
        return c;
    endfunction

    // True when older instruction p writes a register that c reads
    function automatic bit writes_src(mc_t p, mc_t c);
        return p.ok && p.rw && p.dst != 0 && (p.dst == c.ra || p.dst == c.rb);
    endfunction

    function automatic int fsel(logic [4:0] src);
        if (src == 0) return 0;
        if (m_mem.ok && m_mem.rw && m_mem.dst == src) return 2;
        if (m_wb.ok && m_wb.rw && m_wb.dst == src) return 1;
        return 0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive();
        bus.id_valid = id_cur.v;
        bus.op       = id_cur.op;
        bus.func     = id_cur.func;
        bus.rs       = id_cur.rs;
        bus.rt       = id_cur.rt;
        bus.rd       = id_cur.rd;
        bus.zero     = zval;
    endtask

    function automatic int count(int which, int val, int n);
        int k;
        k = 0;
        for (int c = 0; c < n; c++) begin
            case (which)
                0: if (tr_pcw[c] == val) k++;
                1: if (tr_irw[c] == val) k++;
                2: if (tr_ill[c] == val) k++;
                3: if (tr_mw[c] == val) k++;
                4: if (tr_rw[c] == 1 && tr_rd[c] == val) k++;
                default: if (tr_rw[c] == val) k++;
            endcase
        end
        return k;
    endfunction

    // Fetch unit + per-cycle comparison against the instruction-level model
    task automatic run(int ncyc, int rst_cyc);
        mc_t cur;
        bit  taken, jmp, flush, haz, stall;
        ptr    = 1;
        id_cur = (prog.size() > 0) ? prog[0] : '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            rst = (c == rst_cyc);
            drive();
            #1;
            cur   = mdec(id_cur);
            taken = m_ex.ok && ((m_ex.beq && zval) || (m_ex.bne && !zval));
            jmp   = m_ex.ok && m_ex.jmp;
            flush = taken || jmp;
`ifdef CU_PIPE5_FORWARD_EN
            haz = m_ex.m2r && writes_src(m_ex, cur);
`else
            haz = writes_src(m_ex, cur) || writes_src(m_mem, cur);
`endif
            stall = haz && !flush;
            chk("PCWre", bus.PCWre, !stall);
            chk("IRWre", bus.IRWre, !stall);
            chk("id_flush", bus.id_flush, flush);
            chk("ALUControl", bus.ALUControl, m_ex.alu);
            chk("ALUSrcA", bus.ALUSrcA, m_ex.srca);
            chk("ALUSrcB", bus.ALUSrcB, m_ex.srcb);
            chk("Extend", bus.Extend, m_ex.ext);
            chk("Branch", bus.Branch, jmp ? 2 : (taken ? 1 : 0));
            chk("MemWrite", bus.MemWrite, m_mem.mw);
            chk("MemtoReg", bus.MemtoReg, m_wb.m2r);
            chk("PCtoReg", bus.PCtoReg, m_wb.pc2r);
            chk("RegWrite", bus.RegWrite, m_wb.rw);
            chk("wb_rdst", bus.wb_rdst, m_wb.dst);
            chk("illegal", bus.illegal, m_ill);
`ifdef CU_PIPE5_FORWARD_EN
            chk("fwd_a", bus.fwd_a, m_ex.ok ? fsel(m_ex.ra) : 0);
            chk("fwd_b", bus.fwd_b, m_ex.ok ? fsel(m_ex.rb) : 0);
`else
            chk("fwd_a", bus.fwd_a, 0);
            chk("fwd_b", bus.fwd_b, 0);
`endif
            tr_pcw[c] = bus.PCWre;   tr_irw[c] = bus.IRWre;   tr_fl[c] = bus.id_flush;
            tr_br[c]  = bus.Branch;  tr_rw[c]  = bus.RegWrite; tr_rd[c] = bus.wb_rdst;
            tr_pc2r[c] = bus.PCtoReg; tr_alu[c] = bus.ALUControl; tr_srcb[c] = bus.ALUSrcB;
            tr_ill[c] = bus.illegal; tr_mw[c] = bus.MemWrite; tr_fa[c] = bus.fwd_a; tr_fb[c] = bus.fwd_b;
            @(posedge clk);
            if (rst) begin
                m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0;
                id_cur = '0;
            end else begin
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = (cur.ok && !flush && !stall) ? cur : '0;
                m_ill = id_cur.v && !cur.ok && !flush;
                if (flush) id_cur = '0;
                else if (!stall) begin
                    id_cur = (ptr < prog.size()) ? prog[ptr] : '0;
                    ptr++;
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        id_cur = '0; zval = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst PCWre", bus.PCWre, 1);
        chk("rst IRWre", bus.IRWre, 1);
        chk("rst id_flush", bus.id_flush, 0);
        chk("rst RegWrite", bus.RegWrite, 0);
        chk("rst wb_rdst", bus.wb_rdst, 0);
        chk("rst illegal", bus.illegal, 0);

        // add $3,$1,$2
        prog = {mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd3)};
        run(8, -1);
        chk("add ALUControl", tr_alu[1], 0);
        chk("add ALUSrcB", tr_srcb[1], 0);
        chk("add early RegWrite", tr_rw[2], 0);
        chk("add RegWrite", tr_rw[3], 1);
        chk("add wb_rdst", tr_rd[3], 3);

        // lw $4,0($1); add $5,$4,$1
        prog = {mk(6'h23, 6'h00, 5'd1, 5'd4, 5'd0), mk(6'h00, 6'h20, 5'd4, 5'd1, 5'd5)};
        run(10, -1);
        chk("lu PCWre low cycles", count(0, 0, 10), N_LU);
        chk("lu IRWre low cycles", count(1, 0, 10), N_LU);
        chk("lu lw wb_rdst", tr_rd[3], 4);
        chk("lu add RegWrite", tr_rw[4 + N_LU], 1);
        chk("lu add wb_rdst", tr_rd[4 + N_LU], 5);

        // beq taken kills the next instruction
        zval = 1'b1;
        prog = {mk(6'h04, 6'h00, 5'd1, 5'd2, 5'd0), mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd7),
                mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd8)};
        run(10, -1);
        chk("beq taken Branch", tr_br[1], 1);
        chk("beq taken id_flush", tr_fl[1], 1);
        chk("beq taken PCWre", tr_pcw[1], 1);
        chk("beq killed writes", count(4, 7, 10), 0);
        chk("beq survivor wb_rdst", tr_rd[6], 8);

        // beq not taken
        zval = 1'b0;
        prog = {mk(6'h04, 6'h00, 5'd1, 5'd2, 5'd0), mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd7)};
        run(8, -1);
        chk("beq nt Branch", tr_br[1], 0);
        chk("beq nt id_flush", tr_fl[1], 0);
        chk("beq nt add wb_rdst", tr_rd[4], 7);

        // jal
        prog = {mk(6'h03, 6'h00, 5'd0, 5'd0, 5'd0), mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd9)};
        run(8, -1);
        chk("jal Branch", tr_br[1], 2);
        chk("jal RegWrite", tr_rw[3], 1);
        chk("jal PCtoReg", tr_pc2r[3], 1);
        chk("jal wb_rdst", tr_rd[3], 31);
        chk("jal killed writes", count(4, 9, 8), 0);

        // add $3; sub $6,$3,$3
        prog = {mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd3), mk(6'h00, 6'h22, 5'd3, 5'd3, 5'd6)};
        run(10, -1);
        chk("raw stall cycles", count(0, 0, 10), N_RAW);
        chk("raw sub ALUControl", tr_alu[2 + N_RAW], 1);
`ifdef CU_PIPE5_FORWARD_EN
        chk("raw fwd_a", tr_fa[2], 2);
        chk("raw fwd_b", tr_fb[2], 2);
`endif
        chk("raw sub wb_rdst", tr_rd[4 + N_RAW], 6);

        // op 3f then add $10
        prog = {mk(6'h3f, 6'h00, 5'd1, 5'd2, 5'd3), mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd10)};
        run(8, -1);
        chk("ill pulse", tr_ill[1], 1);
        chk("ill pulse count", count(2, 1, 8), 1);
        chk("ill no MemWrite", count(3, 1, 8), 0);
        chk("ill RegWrite count", count(5, 1, 8), 1);
        chk("ill add wb_rdst", tr_rd[4], 10);

        // mid-stream reset
        prog = {mk(6'h00, 6'h22, 5'd1, 5'd2, 5'd3), mk(6'h00, 6'h22, 5'd1, 5'd2, 5'd4),
                mk(6'h00, 6'h22, 5'd1, 5'd2, 5'd5)};
        run(8, 2);
        chk("mid pre ALUControl", tr_alu[2], 1);
        chk("mid post ALUControl", tr_alu[3], 0);
        chk("mid post RegWrite", tr_rw[3], 0);
        chk("mid post wb_rdst", tr_rd[3], 0);
        chk("mid post PCWre", tr_pcw[3], 1);
        chk("mid no retire", count(5, 1, 8), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
